seq_controller: RTL and testbench

SEQ_CONTROLLER -- requirements
Module: seq_controller

---
 rtl/seq_controller_if.sv | 50 +++++
 rtl/seq_controller.sv | 200 ++++++++++++++++++++
 tb/tb_seq_controller.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_controller_if.sv
// seq_controller_if: bundles the sequencer's decode inputs, datapath controls and status.
//   master : the sequencer side (takes opcode/run/mem_ready/acc_zero, drives controls/status)
//   slave  : the datapath/memory side (mirror image of master)
// Parameter OPW sets the opcode field width.
interface seq_controller_if #(
  parameter int unsigned OPW = 3
);
  // Inputs to the sequencer
  logic [OPW-1:0] opcode;
  logic           run;
  logic           mem_ready;
  logic           acc_zero;
  // Datapath register controls
  logic           load_IR;
  logic           load_acc;
  logic           ld_pc;
  logic           clr_pc;
  logic           inc_pc;
  // Accumulator source / ALU selects
  logic           sel_alu;
  logic           sel_bus;
  logic           pass_add;
  logic           sub_en;
  // Address mux and memory strobes
  logic           ir_on_adr;
  logic           pc_on_adr;
  logic           mem_read;
  logic           mem_write;
  // Status
  logic           halted;
  logic           timeout;
  logic           illegal_op;
  logic [2:0]     state;

  modport master (
    input  opcode, run, mem_ready, acc_zero,
    output load_IR, load_acc, ld_pc, clr_pc, inc_pc,
    output sel_alu, sel_bus, pass_add, sub_en,
    output ir_on_adr, pc_on_adr, mem_read, mem_write,
    output halted, timeout, illegal_op, state
  );

  modport slave (
    output opcode, run, mem_ready, acc_zero,
    input  load_IR, load_acc, ld_pc, clr_pc, inc_pc,
    input  sel_alu, sel_bus, pass_add, sub_en,
    input  ir_on_adr, pc_on_adr, mem_read, mem_write,
    input  halted, timeout, illegal_op, state
  );
endinterface

// File: rtl/seq_controller.sv
// seq_controller: fetch/decode/execute sequencer for a simple accumulator machine.
//   clock     : system clock, rising edge
//   reset     : asynchronous active-high reset
//   bus       : seq_controller_if.master -- opcode/run/mem_ready/acc_zero in,
//               datapath controls, memory strobes, status flags and state code out
// Parameters: OPW (opcode width, 3..8), MAX_WAIT (memory wait cycles before timeout, 1..255).
module seq_controller #(
  parameter int unsigned OPW      = 3,
  parameter int unsigned MAX_WAIT = 15
) (
  input logic              clock,
  input logic              reset,
  seq_controller_if.master bus
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  localparam logic [2:0] OpAdd   = 3'b000;
  localparam logic [2:0] OpLoad  = 3'b001;
  localparam logic [2:0] OpStore = 3'b010;
  localparam logic [2:0] OpSub   = 3'b011;
  localparam logic [2:0] OpJmp   = 3'b100;
  localparam logic [2:0] OpJz    = 3'b101;
  localparam logic [2:0] OpHalt  = 3'b110;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StHalt   = 3'd4,
    StError  = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              illegal_q, illegal_d;

  logic [OPW-1:0]    opcode;
  logic [2:0]        op_lo;
  logic              op_illegal;
  logic              mem_op;
  logic              wait_state;
  logic              cnt_expired;

  assign opcode      = bus.opcode;
  assign op_lo       = opcode[2:0];
  // Any set bit above the 3-bit opcode field is illegal; zero for OPW == 3.
  assign op_illegal  = (opcode >> 3) != '0;
  // ADD/LOAD/STORE/SUB all have bit 2 clear.
  assign mem_op      = !op_illegal && !op_lo[2];
  assign wait_state  = (state_q == StFetch) || ((state_q == StExec) && mem_op);
  assign cnt_expired = (cnt_q == CntW'(MAX_WAIT));

  // State register and sticky error flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    illegal_d = illegal_q;
    case (state_q)
      StIdle: begin
        if (bus.run) state_d = StFetch;
      end
      StFetch: begin
        // Ready wins over an expiring wait counter.
        if (bus.mem_ready) begin
          state_d = StDecode;
        end else if (cnt_expired) begin
          state_d   = StError;
          timeout_d = 1'b1;
        end
      end
      StDecode: begin
        if (op_illegal) begin
          state_d   = StError;
          illegal_d = 1'b1;
        end else if (op_lo == OpHalt) begin
          state_d = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (!mem_op || bus.mem_ready) begin
          state_d = StFetch;
        end else if (cnt_expired) begin
          state_d   = StError;
          timeout_d = 1'b1;
        end
      end
      StHalt: begin
        if (bus.run) state_d = StFetch;
      end
      StError: begin
        state_d = StError;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Wait counter: cleared on any state change, counts not-ready cycles while waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (wait_state && !bus.mem_ready) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Output logic
  always_comb begin
    bus.load_IR   = 1'b0;
    bus.load_acc  = 1'b0;
    bus.ld_pc     = 1'b0;
    bus.clr_pc    = 1'b0;
    bus.inc_pc    = 1'b0;
    bus.sel_alu   = 1'b0;
    bus.sel_bus   = 1'b0;
    bus.pass_add  = 1'b0;
    bus.sub_en    = 1'b0;
    bus.ir_on_adr = 1'b0;
    bus.pc_on_adr = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.halted    = 1'b0;
    case (state_q)
      StIdle: begin
        bus.clr_pc = 1'b1;
      end
      StFetch: begin
        bus.pc_on_adr = 1'b1;
        bus.mem_read  = 1'b1;
        bus.load_IR   = bus.mem_ready;
        bus.inc_pc    = bus.mem_ready;
      end
      StExec: begin
        // An opcode that turns illegal after DECODE behaves as a NOP here.
        if (!op_illegal) begin
          case (op_lo)
            OpAdd, OpSub: begin
              bus.ir_on_adr = 1'b1;
              bus.mem_read  = 1'b1;
              bus.sel_alu   = 1'b1;
              bus.pass_add  = (op_lo == OpAdd);
              bus.sub_en    = (op_lo == OpSub);
              bus.load_acc  = bus.mem_ready;
            end
            OpLoad: begin
              bus.ir_on_adr = 1'b1;
              bus.mem_read  = 1'b1;
              bus.sel_bus   = 1'b1;
              bus.load_acc  = bus.mem_ready;
            end
            OpStore: begin
              bus.ir_on_adr = 1'b1;
              bus.mem_write = 1'b1;
            end
            OpJmp: begin
              bus.ld_pc = 1'b1;
            end
            OpJz: begin
              bus.ld_pc = bus.acc_zero;
            end
            default: begin
            end
          endcase
        end
      end
      StHalt: begin
        bus.halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.timeout    = timeout_q;
  assign bus.illegal_op = illegal_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_seq_controller.sv
// Directed, table-driven bench for seq_controller (OPW=4, MAX_WAIT=15).
module tb_seq_controller;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FET  = 3'd1;
  localparam logic [2:0] S_DEC  = 3'd2;
  localparam logic [2:0] S_EXE  = 3'd3;
  localparam logic [2:0] S_HLT  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  // Control vector bit masks, packed in port order
  localparam logic [15:0] LIR  = 16'h8000;
  localparam logic [15:0] LACC = 16'h4000;
  localparam logic [15:0] LDPC = 16'h2000;
  localparam logic [15:0] CLR  = 16'h1000;
  localparam logic [15:0] INC  = 16'h0800;
  localparam logic [15:0] ALU  = 16'h0400;
  localparam logic [15:0] BUS  = 16'h0200;
  localparam logic [15:0] PADD = 16'h0100;
  localparam logic [15:0] SUB  = 16'h0080;
  localparam logic [15:0] IRA  = 16'h0040;
  localparam logic [15:0] PCA  = 16'h0020;
  localparam logic [15:0] RD   = 16'h0010;
  localparam logic [15:0] WR   = 16'h0008;
  localparam logic [15:0] HLT  = 16'h0004;
  localparam logic [15:0] TMO  = 16'h0002;
  localparam logic [15:0] ILL  = 16'h0001;
  localparam logic [15:0] NONE = 16'h0000;

  typedef struct {
    logic        run;
    logic        mr;
    logic        az;
    logic [3:0]  op;
    logic [2:0]  st;
    logic [15:0] ctl;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  seq_controller_if #(.OPW(4)) bus ();

  seq_controller #(
    .OPW      (4),
    .MAX_WAIT (15)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(logic run, logic mr, logic az, logic [3:0] op,
                              logic [2:0] st, logic [15:0] ctl);
    vec_t v;
    v.run = run; v.mr = mr; v.az = az; v.op = op; v.st = st; v.ctl = ctl;
    return v;
  endfunction

  function automatic void add(logic run, logic mr, logic az, logic [3:0] op,
                              logic [2:0] st, logic [15:0] ctl);
    vecs.push_back(mk(run, mr, az, op, st, ctl));
  endfunction

  task automatic check(input string name, input logic [2:0] st, input logic [15:0] ctl);
    logic [15:0] act;
    act = {bus.load_IR, bus.load_acc, bus.ld_pc, bus.clr_pc, bus.inc_pc, bus.sel_alu,
           bus.sel_bus, bus.pass_add, bus.sub_en, bus.ir_on_adr, bus.pc_on_adr,
           bus.mem_read, bus.mem_write, bus.halted, bus.timeout, bus.illegal_op};
    n_vec++;
    if (bus.state !== st || act !== ctl) begin
      n_fail++;
      $display("FAIL %s: got state=%0d ctl=%04h, expected state=%0d ctl=%04h",
               name, bus.state, act, st, ctl);
    end
  endtask

  // Drive inputs just after an edge, check mid-cycle, then advance one edge.
  task automatic apply(input string name, input vec_t v);
    bus.run       = v.run;
    bus.mem_ready = v.mr;
    bus.acc_zero  = v.az;
    bus.opcode    = v.op;
    #2;
    check(name, v.st, v.ctl);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    bus.run = 1'b0; bus.mem_ready = 1'b0; bus.acc_zero = 1'b0; bus.opcode = 4'h0;
    reset = 1'b1;
    #2;
    check("reset_active", S_IDLE, CLR);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.run = 1'b0; bus.mem_ready = 1'b0; bus.acc_zero = 1'b0; bus.opcode = 4'h0;

    // run, mem_ready, acc_zero, opcode, expected state, expected controls
    add(0, 0, 0, 4'h0, S_IDLE, CLR);
    add(1, 0, 0, 4'h0, S_IDLE, CLR);
    add(1, 1, 0, 4'h0, S_FET,  PCA | RD | LIR | INC);          // ADD
    add(1, 1, 0, 4'h0, S_DEC,  NONE);
    add(1, 1, 0, 4'h0, S_EXE,  IRA | RD | ALU | PADD | LACC);
    add(0, 1, 0, 4'h2, S_FET,  PCA | RD | LIR | INC);          // STORE, 3 waits
    add(0, 1, 0, 4'h2, S_DEC,  NONE);
    add(0, 0, 0, 4'h2, S_EXE,  IRA | WR);
    add(0, 0, 0, 4'h2, S_EXE,  IRA | WR);
    add(0, 0, 0, 4'h2, S_EXE,  IRA | WR);
    add(0, 1, 0, 4'h2, S_EXE,  IRA | WR);
    add(0, 1, 0, 4'h3, S_FET,  PCA | RD | LIR | INC);          // SUB, 1 wait
    add(0, 1, 0, 4'h3, S_DEC,  NONE);
    add(0, 0, 0, 4'h3, S_EXE,  IRA | RD | ALU | SUB);
    add(0, 1, 0, 4'h3, S_EXE,  IRA | RD | ALU | SUB | LACC);
    add(0, 1, 0, 4'h1, S_FET,  PCA | RD | LIR | INC);          // LOAD
    add(0, 1, 0, 4'h1, S_DEC,  NONE);
    add(0, 1, 0, 4'h1, S_EXE,  IRA | RD | BUS | LACC);
    add(0, 1, 0, 4'h5, S_FET,  PCA | RD | LIR | INC);          // JZ not taken
    add(0, 1, 0, 4'h5, S_DEC,  NONE);
    add(0, 1, 0, 4'h5, S_EXE,  NONE);
    add(0, 1, 1, 4'h5, S_FET,  PCA | RD | LIR | INC);          // JZ taken
    add(0, 1, 1, 4'h5, S_DEC,  NONE);
    add(0, 1, 1, 4'h5, S_EXE,  LDPC);
    add(0, 1, 1, 4'h4, S_FET,  PCA | RD | LIR | INC);          // JMP
    add(0, 1, 0, 4'h4, S_DEC,  NONE);
    add(0, 1, 0, 4'h4, S_EXE,  LDPC);
    add(0, 1, 0, 4'h7, S_FET,  PCA | RD | LIR | INC);          // NOP
    add(0, 1, 0, 4'h7, S_DEC,  NONE);
    add(0, 1, 0, 4'h7, S_EXE,  NONE);
    add(0, 1, 0, 4'h6, S_FET,  PCA | RD | LIR | INC);          // HALT
    add(0, 1, 0, 4'h6, S_DEC,  NONE);
    add(0, 1, 0, 4'h6, S_HLT,  HLT);
    add(0, 1, 0, 4'h6, S_HLT,  HLT);
    add(1, 1, 0, 4'h6, S_HLT,  HLT);
    add(0, 1, 0, 4'h8, S_FET,  PCA | RD | LIR | INC);          // resume, no clr_pc
    add(0, 1, 0, 4'h8, S_DEC,  NONE);                          // illegal high bit
    add(1, 1, 0, 4'h8, S_ERR,  ILL);
    add(1, 1, 0, 4'h0, S_ERR,  ILL);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      apply($sformatf("vec[%0d]", i), vecs[i]);
    end

    // Reset clears the sticky illegal_op flag.
    do_reset();
    apply("post_reset_idle", mk(0, 0, 0, 4'h0, S_IDLE, CLR));

    // Fetch timeout: 16 not-ready cycles in FETCH, then ERROR; run ignored.
    apply("to_idle_run", mk(1, 0, 0, 4'h0, S_IDLE, CLR));
    for (int i = 0; i < 16; i++) begin
      apply($sformatf("to_fetch_wait[%0d]", i), mk(0, 0, 0, 4'h0, S_FET, PCA | RD));
    end
    apply("to_error_0", mk(1, 0, 0, 4'h0, S_ERR, TMO));
    apply("to_error_1", mk(1, 1, 0, 4'h0, S_ERR, TMO));
    do_reset();
    apply("to_cleared", mk(0, 0, 0, 4'h0, S_IDLE, CLR));

    // Ready in the last allowed cycle wins; counter restarts in EXEC.
    apply("rw_idle_run", mk(1, 0, 0, 4'h0, S_IDLE, CLR));
    for (int i = 0; i < 15; i++) begin
      apply($sformatf("rw_fetch_wait[%0d]", i), mk(0, 0, 0, 4'h0, S_FET, PCA | RD));
    end
    apply("rw_fetch_ready", mk(0, 1, 0, 4'h0, S_FET, PCA | RD | LIR | INC));
    apply("rw_decode", mk(0, 0, 0, 4'h0, S_DEC, NONE));
    for (int i = 0; i < 15; i++) begin
      apply($sformatf("rw_exec_wait[%0d]", i), mk(0, 0, 0, 4'h0, S_EXE, IRA | RD | ALU | PADD));
    end
    apply("rw_exec_ready", mk(0, 1, 0, 4'h0, S_EXE, IRA | RD | ALU | PADD | LACC));
    apply("rw_back_fetch", mk(0, 1, 0, 4'h0, S_FET, PCA | RD | LIR | INC));

    // Reset mid-EXEC with mem_read active drops the strobe without a clock edge.
    apply("mr_decode", mk(0, 0, 0, 4'h0, S_DEC, NONE));
    bus.mem_ready = 1'b0;
    #2;
    check("mr_exec_before", S_EXE, IRA | RD | ALU | PADD);
    #1;
    reset = 1'b1;
    #1;
    check("mr_exec_async_reset", S_IDLE, CLR);
    @(posedge clock);
    #1;
    reset = 1'b0;
    apply("mr_stay_idle_0", mk(0, 1, 0, 4'h0, S_IDLE, CLR));
    apply("mr_stay_idle_1", mk(0, 1, 0, 4'h0, S_IDLE, CLR));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
